// File: rtl/bcd_7seg_if.sv
// bcd_7seg_if: value/segment handshake bundle between a data producer and
// bcd_7seg_driver. The producer side uses the master modport, the driver
// uses the slave modport.
interface bcd_7seg_if #(
   parameter int DATA_W = 9,
   parameter int DIGITS = 3
);
   logic [DATA_W-1:0]       i_data;
   logic                    i_valid;
   logic                    o_ready;
   logic [8*(DIGITS+1)-1:0] o_seg;
   logic                    o_done;
   logic                    o_overflow;

   modport master (
      output i_data,
      output i_valid,
      input  o_ready,
      input  o_seg,
      input  o_done,
      input  o_overflow
   );

   modport slave (
      input  i_data,
      input  i_valid,
      output o_ready,
      output o_seg,
      output o_done,
      output o_overflow
   );
endinterface

// File: rtl/bcd_7seg_driver.sv
// bcd_7seg_driver: sequential signed/unsigned binary to seven-segment driver.
// A word accepted over valid/ready is converted to DIGITS decimal digits by an
// iterative shift-and-add-3 (double-dabble) engine, one bit per cycle, then
// registered as active-low segment bytes plus a sign digit.
// Optional feature macro: BCD7SEG_LZ_BLANK_EN (leading-zero blanking).
module bcd_7seg_driver #(
   parameter int DATA_W = 9,
   parameter int DIGITS = 3,
   parameter int SIGNED = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   bcd_7seg_if.slave     io_bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SEG_W = 8 * (DIGITS + 1);
   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_ZERO  = 8'hC0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_LOAD
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic               w_ready;
   logic               w_accept;

   logic [DATA_W-1:0]  r_shift;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_sticky;
   logic               r_neg;
   logic [CNT_W-1:0]   r_cnt;

   logic [DATA_W-1:0]  w_mag;
   logic               w_neg;
   logic [BCD_W-1:0]   w_bcd_adj;
   logic [SEG_W-1:0]   w_seg_next;

   logic [SEG_W-1:0]   r_seg;
   logic               r_done;
   logic               r_overflow;

   // Active-low segment code for one BCD digit; codes 10..15 never occur.
   function automatic logic [7:0] f_digit_seg(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'd0:    seg = SEG_ZERO;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h98;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Display image after reset: a zero in the ones digit, sign blank, and the
   // upper digits either zero or blanked depending on leading-zero blanking.
   function automatic logic [SEG_W-1:0] f_reset_seg();
      logic [SEG_W-1:0] seg;
      seg      = '1;
      seg[7:0] = SEG_ZERO;
`ifndef BCD7SEG_LZ_BLANK_EN
      for (int d = 1; d < DIGITS; d++) begin
         seg[8*d +: 8] = SEG_ZERO;
      end
`endif
      return seg;
   endfunction

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and handshake decode; ready depends on state only.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned (which would infer a latch).
      w_next_state = r_state;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (io_bus.i_valid) begin
               w_accept     = 1'b1;
               w_next_state = S_CONV;
            end
         end
         S_CONV: begin
            if (r_cnt == CNT_W'(1)) begin
               w_next_state = S_LOAD;
            end
         end
         S_LOAD: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   assign io_bus.o_ready = w_ready;

   // Magnitude and sign of the incoming word; the most negative value wraps
   // to its own bit pattern, which read unsigned is the correct magnitude.
   always_comb begin
      w_mag = io_bus.i_data;
      w_neg = 1'b0;
      if ((SIGNED != 0) && io_bus.i_data[DATA_W-1]) begin
         w_neg = 1'b1;
         w_mag = -io_bus.i_data;
      end
   end

   // Add-3 correction: every nibble of 5 or more is bumped before the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5) begin
            w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
         end
      end
   end

   // Conversion datapath: load on accept, one shift-and-add-3 step per cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift  <= '0;
         r_bcd    <= '0;
         r_sticky <= 1'b0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shift  <= w_mag;
                  r_neg    <= w_neg;
                  r_bcd    <= '0;
                  r_sticky <= 1'b0;
                  r_cnt    <= CNT_W'(DATA_W);
               end
            end
            S_CONV: begin
               // A bit leaving the top nibble means the value needs more
               // digits than are fitted; it latches into the sticky flag.
               r_bcd    <= {w_bcd_adj[BCD_W-2:0], r_shift[DATA_W-1]};
               r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
               r_sticky <= r_sticky | w_bcd_adj[BCD_W-1];
               r_cnt    <= r_cnt - CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Segment image of the finished conversion: dashes on overflow, optional
   // leading-zero blanking, sign digit from the latched sign.
   always_comb begin
`ifdef BCD7SEG_LZ_BLANK_EN
      logic lead;
      lead = 1'b1;
`endif
      w_seg_next = '1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         if (r_sticky) begin
            w_seg_next[8*d +: 8] = SEG_DASH;
         end else begin
`ifdef BCD7SEG_LZ_BLANK_EN
            if (lead && (r_bcd[4*d +: 4] == 4'd0) && (d != 0)) begin
               w_seg_next[8*d +: 8] = SEG_BLANK;
            end else begin
               lead                 = 1'b0;
               w_seg_next[8*d +: 8] = f_digit_seg(r_bcd[4*d +: 4]);
            end
`else
            w_seg_next[8*d +: 8] = f_digit_seg(r_bcd[4*d +: 4]);
`endif
         end
      end
      w_seg_next[8*DIGITS +: 8] = ((SIGNED != 0) && r_neg) ? SEG_DASH : SEG_BLANK;
   end

   // Output registers: updated only in LOAD, done pulses for that one cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_seg      <= f_reset_seg();
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_done <= (r_state == S_LOAD);
         if (r_state == S_LOAD) begin
            r_seg      <= w_seg_next;
            r_overflow <= r_sticky;
         end
      end
   end

   assign io_bus.o_seg      = r_seg;
   assign io_bus.o_done     = r_done;
   assign io_bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_bcd_7seg_driver.sv
// tb_bcd_7seg_driver: scoreboard bench for bcd_7seg_driver. Three instances:
// A (DATA_W=9, DIGITS=3, signed), B (DATA_W=9, DIGITS=2, signed) for
// overflow, C (DATA_W=8, DIGITS=3, unsigned). Drivers push expected results
// on issue; per-instance monitors pop and compare on o_done.
module tb_bcd_7seg_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bcd_7seg_if #(.DATA_W(9), .DIGITS(3)) bus_a ();
   bcd_7seg_if #(.DATA_W(9), .DIGITS(2)) bus_b ();
   bcd_7seg_if #(.DATA_W(8), .DIGITS(3)) bus_c ();

   bcd_7seg_driver #(.DATA_W(9), .DIGITS(3), .SIGNED(1)) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus_a)
   );
   bcd_7seg_driver #(.DATA_W(9), .DIGITS(2), .SIGNED(1)) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus_b)
   );
   bcd_7seg_driver #(.DATA_W(8), .DIGITS(3), .SIGNED(0)) dut_c (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus_c)
   );

`ifdef BCD7SEG_LZ_BLANK_EN
   localparam logic [31:0] EXP_RST  = 32'hFFFFFFC0;
   localparam logic [31:0] EXP_M45  = 32'hBFFF9992;
   localparam logic [31:0] EXP_ZERO = 32'hFFFFFFC0;
   localparam logic [31:0] EXP_M1   = 32'hBFFFFFF9;
   localparam logic [31:0] EXP_12   = 32'hFFFFF9A4;
   localparam logic [31:0] EXP_99   = 32'hFFFF9898;
   localparam logic [31:0] EXP_C5   = 32'hFFFFFF92;
`else
   localparam logic [31:0] EXP_RST  = 32'hFFC0C0C0;
   localparam logic [31:0] EXP_M45  = 32'hBFC09992;
   localparam logic [31:0] EXP_ZERO = 32'hFFC0C0C0;
   localparam logic [31:0] EXP_M1   = 32'hBFC0C0F9;
   localparam logic [31:0] EXP_12   = 32'hFFC0F9A4;
   localparam logic [31:0] EXP_99   = 32'hFFC09898;
   localparam logic [31:0] EXP_C5   = 32'hFFC0C092;
`endif

   typedef struct {
      logic [31:0] seg;
      logic        ovf;
      int          acc_cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor A: result, overflow and accept-to-done latency (DATA_W+1 edges).
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n && bus_a.o_done) begin
         if (q_a.size() == 0) begin
            n_checks++;
            $display("FAIL a_unexpected_done: got o_done=1 with no pending result (cycle %0d)", cyc);
         end else begin
            e = q_a.pop_front();
            check("a_seg", 64'(bus_a.o_seg), 64'(e.seg));
            check("a_ovf", 64'(bus_a.o_overflow), 64'(e.ovf));
            check("a_latency", 64'(cyc - e.acc_cyc), 64'd10);
         end
      end
   end

   // Monitor B: result and overflow.
   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst_n && bus_b.o_done) begin
         if (q_b.size() == 0) begin
            n_checks++;
            $display("FAIL b_unexpected_done: got o_done=1 with no pending result (cycle %0d)", cyc);
         end else begin
            e = q_b.pop_front();
            check("b_seg", 64'({8'h00, bus_b.o_seg}), 64'(e.seg));
            check("b_ovf", 64'(bus_b.o_overflow), 64'(e.ovf));
         end
      end
   end

   // Monitor C: result and overflow.
   always @(negedge clk) begin : mon_c
      exp_t e;
      if (rst_n && bus_c.o_done) begin
         if (q_c.size() == 0) begin
            n_checks++;
            $display("FAIL c_unexpected_done: got o_done=1 with no pending result (cycle %0d)", cyc);
         end else begin
            e = q_c.pop_front();
            check("c_seg", 64'(bus_c.o_seg), 64'(e.seg));
            check("c_ovf", 64'(bus_c.o_overflow), 64'(e.ovf));
         end
      end
   end

   // Issue one word to A; hold keeps i_valid asserted after the accept.
   task automatic send_a(input logic [8:0] d, input logic [31:0] seg, input logic ovf, input bit hold);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      bus_a.i_data  = d;
      bus_a.i_valid = 1'b1;
      while (!bus_a.o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus_a.o_ready) begin
         n_checks++;
         $display("FAIL a_ready_timeout: got o_ready=0 expected 1 within 100 cycles");
         bus_a.i_valid = 1'b0;
         return;
      end
      if (n > 0) check("a_ready_with_done", 64'(bus_a.o_done), 64'd1);
      e.seg     = seg;
      e.ovf     = ovf;
      e.acc_cyc = cyc + 1;
      q_a.push_back(e);
      @(posedge clk);
      if (!hold) begin
         @(negedge clk);
         bus_a.i_valid = 1'b0;
      end
   endtask

   task automatic send_b(input logic [8:0] d, input logic [23:0] seg, input logic ovf);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      bus_b.i_data  = d;
      bus_b.i_valid = 1'b1;
      while (!bus_b.o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus_b.o_ready) begin
         n_checks++;
         $display("FAIL b_ready_timeout: got o_ready=0 expected 1 within 100 cycles");
         bus_b.i_valid = 1'b0;
         return;
      end
      e.seg     = {8'h00, seg};
      e.ovf     = ovf;
      e.acc_cyc = cyc + 1;
      q_b.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus_b.i_valid = 1'b0;
   endtask

   task automatic send_c(input logic [7:0] d, input logic [31:0] seg, input logic ovf);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      bus_c.i_data  = d;
      bus_c.i_valid = 1'b1;
      while (!bus_c.o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus_c.o_ready) begin
         n_checks++;
         $display("FAIL c_ready_timeout: got o_ready=0 expected 1 within 100 cycles");
         bus_c.i_valid = 1'b0;
         return;
      end
      e.seg     = seg;
      e.ovf     = ovf;
      e.acc_cyc = cyc + 1;
      q_c.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus_c.i_valid = 1'b0;
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_seg"},   64'(bus_a.o_seg),      64'(EXP_RST));
      check({tag, "_ready"}, 64'(bus_a.o_ready),    64'd1);
      check({tag, "_done"},  64'(bus_a.o_done),     64'd0);
      check({tag, "_ovf"},   64'(bus_a.o_overflow), 64'd0);
   endtask

   initial begin
      int n;
      bus_a.i_valid = 1'b0;
      bus_a.i_data  = '0;
      bus_b.i_valid = 1'b0;
      bus_b.i_data  = '0;
      bus_c.i_valid = 1'b0;
      bus_c.i_data  = '0;
      rst_n         = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_a("rst");
      rst_n = 1'b1;

      // Directed signed vectors on A.
      send_a(9'd137, 32'hFFF9B0F8, 1'b0, 1'b0);
      send_a(9'h1D3, EXP_M45,      1'b0, 1'b0);
      send_a(9'h100, 32'hBFA49282, 1'b0, 1'b0);
      send_a(9'd0,   EXP_ZERO,     1'b0, 1'b0);
      send_a(9'h1FF, EXP_M1,       1'b0, 1'b0);
      send_a(9'd255, 32'hFFA49292, 1'b0, 1'b0);

      // Busy source: +12 accepted, i_data changes to +99 with i_valid held.
      send_a(9'd12, EXP_12, 1'b0, 1'b1);
      @(negedge clk);
      bus_a.i_data = 9'd99;
      repeat (5) begin
         check("a_ready_busy", 64'(bus_a.o_ready), 64'd0);
         @(negedge clk);
      end
      send_a(9'd99, EXP_99, 1'b0, 1'b0);

      // Reset 4 cycles into a conversion: abort, no done, then recover.
      send_a(9'd137, 32'hFFF9B0F8, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      q_a.delete();
      #1;
      check_reset_a("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("abort_idle_seg", 64'(bus_a.o_seg), 64'(EXP_RST));
      send_a(9'h1D3, EXP_M45, 1'b0, 1'b0);

      // Two-digit instance: overflow boundaries.
      send_b(9'd137, 24'hFFBFBF, 1'b1);
      send_b(9'd99,  24'hFF9898, 1'b0);
      send_b(9'h19C, 24'hBFBFBF, 1'b1);

      // Unsigned instance.
      send_c(8'hFF, 32'hFFA49292, 1'b0);
      send_c(8'h80, 32'hFFF9A480, 1'b0);
      send_c(8'h05, EXP_C5,       1'b0);

      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d/%0d/%0d pending results expected 0",
                  q_a.size(), q_b.size(), q_c.size());
      end
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
